// File: rtl/systolic_ws_ctrl.sv
// Weight-stationary systolic array sequencer.
// Loads weights, skews activations in, de-skews results into an output FIFO.
module systolic_ws_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ROW_NUM    = 4,
  parameter int COL_NUM    = 4,
  parameter int OUT_DEPTH  = 16,
  parameter int CNT_W      = 16
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  start,
  input  logic [CNT_W-1:0]                      num_vec,
  output logic                                  busy,
  output logic                                  done,
  input  logic                                  w_valid,
  output logic                                  w_ready,
  input  logic [COL_NUM*DATA_WIDTH-1:0]         w_data,
  input  logic                                  a_valid,
  output logic                                  a_ready,
  input  logic [ROW_NUM*DATA_WIDTH-1:0]         a_data,
  output logic                                  r_valid,
  input  logic                                  r_ready,
  output logic [COL_NUM*DATA_WIDTH-1:0]         r_data,
  output logic [ROW_NUM*COL_NUM*DATA_WIDTH-1:0] arr_weights,
  output logic [COL_NUM*DATA_WIDTH-1:0]         arr_norths,
  output logic [ROW_NUM*DATA_WIDTH-1:0]         arr_wests,
  input  logic [COL_NUM*DATA_WIDTH-1:0]         arr_souths
);

  localparam int DW  = DATA_WIDTH;
  localparam int LAT = ROW_NUM + COL_NUM;
  localparam int CW  = $clog2(OUT_DEPTH + 1);
  localparam int PW  = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam int RW  = (ROW_NUM > 1) ? $clog2(ROW_NUM) : 1;
  localparam int VW  = COL_NUM * DW;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] LOAD_W = 2'd1;
  localparam logic [1:0] STREAM = 2'd2;
  localparam logic [1:0] DRAIN  = 2'd3;

  logic [1:0]       state;
  logic [CNT_W-1:0] nv;
  logic [CNT_W-1:0] issued;
  logic [RW-1:0]    wrow;
  logic [CW-1:0]    inflight;
  logic [CW-1:0]    fcount;
  logic [CW:0]      credit;
  logic [PW-1:0]    wptr;
  logic [PW-1:0]    rptr;
  logic [LAT-1:0]   tag;
  logic [VW-1:0]    fifo_mem [OUT_DEPTH];
  logic [VW-1:0]    aligned;
  logic [ROW_NUM*VW-1:0] wreg;
  logic w_fire;
  logic a_fire;
  logic push;
  logic pop;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(OUT_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign credit  = {1'b0, fcount} + {1'b0, inflight};
  assign w_ready = (state == LOAD_W);
  assign a_ready = (state == STREAM) && (issued < nv)
                && (credit < (CW+1)'(OUT_DEPTH));
  assign w_fire  = w_valid && w_ready;
  assign a_fire  = a_valid && a_ready;
  assign push    = tag[LAT-1];
  assign r_valid = (fcount != '0);
  assign pop     = r_valid && r_ready;
  assign r_data  = r_valid ? fifo_mem[rptr] : '0;
  assign arr_weights = wreg;
  assign arr_norths  = '0;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      nv     <= '0;
      issued <= '0;
      wrow   <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: if (start) begin
          nv     <= num_vec;
          issued <= '0;
          wrow   <= '0;
          busy   <= 1'b1;
          state  <= LOAD_W;
        end
        LOAD_W: if (w_fire) begin
          wrow <= wrow + 1'b1;
          if (wrow == RW'(ROW_NUM - 1)) begin
            wrow  <= '0;
            state <= (nv == '0) ? DRAIN : STREAM;
          end
        end
        STREAM: if (a_fire) begin
          issued <= issued + 1'b1;
          if (issued + 1'b1 == nv) state <= DRAIN;
        end
        DRAIN: if (inflight == '0) begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wreg <= '0;
    end else if (w_fire) begin
      for (int i = 0; i < ROW_NUM; i++)
        if (wrow == RW'(i)) wreg[i*VW +: VW] <= w_data;
    end
  end

  // Row i sits i+1 registers deep so it meets its activation column-wise.
  for (genvar i = 0; i < ROW_NUM; i++) begin : g_skew
    logic [DW-1:0] sr [i+1];
    always_ff @(posedge clk) begin
      if (!reset) begin
        for (int k = 0; k <= i; k++) sr[k] <= '0;
      end else begin
        sr[0] <= a_fire ? a_data[i*DW +: DW] : '0;
        for (int k = 1; k <= i; k++) sr[k] <= sr[k-1];
      end
    end
    assign arr_wests[i*DW +: DW] = sr[i];
  end

  for (genvar j = 0; j < COL_NUM; j++) begin : g_dsk
    localparam int L = COL_NUM - 1 - j;
    if (L == 0) begin : g_pass
      assign aligned[j*DW +: DW] = arr_souths[j*DW +: DW];
    end else begin : g_dly
      logic [DW-1:0] sr [L];
      always_ff @(posedge clk) begin
        if (!reset) begin
          for (int k = 0; k < L; k++) sr[k] <= '0;
        end else begin
          sr[0] <= arr_souths[j*DW +: DW];
          for (int k = 1; k < L; k++) sr[k] <= sr[k-1];
        end
      end
      assign aligned[j*DW +: DW] = sr[L-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      tag      <= '0;
      inflight <= '0;
      fcount   <= '0;
      wptr     <= '0;
      rptr     <= '0;
    end else begin
      tag      <= {tag[LAT-2:0], a_fire};
      inflight <= inflight + CW'(a_fire) - CW'(push);
      fcount   <= fcount + CW'(push) - CW'(pop);
      if (push) wptr <= nxt(wptr);
      if (pop)  rptr <= nxt(rptr);
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wptr] <= aligned;
  end

endmodule

// File: doc/systolic_ws_ctrl.md
Name: systolic_ws_ctrl

Overview:
Sequencer for the weight-stationary systolic array (DATA_WIDTH, ROW_NUM x COL_NUM PEs). It loads a weight matrix row by row, streams activation vectors into the array's west edge with per-row skew and ties the north edge to zero. It de-skews the south-edge partial sums into whole result vectors and buffers them in an output FIFO. Credit-based issue guarantees no result is lost, because the array has no stall input.

Parameters:
DATA_WIDTH, 8, element width; all arithmetic is modulo 2^DATA_WIDTH
ROW_NUM, 4, array rows (weight rows, activation vector length)
COL_NUM, 4, array columns (result vector length)
OUT_DEPTH, 16, output FIFO entries; must be >= ROW_NUM+COL_NUM for full throughput
CNT_W, 16, width of num_vec

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low reset (reset==0 resets on the rising clk edge)
start  in  1  begin a job; ignored while busy
num_vec  in  CNT_W  activation vectors in this job; latched on start
busy  out  1  job in progress
done  out  1  one-cycle pulse at job end
w_valid / w_ready  in / out  1  weight-row handshake
w_data  in  COL_NUM*DATA_WIDTH  one weight row; element j at [j*DW +: DW]
a_valid / a_ready  in / out  1  activation handshake
a_data  in  ROW_NUM*DATA_WIDTH  element i at [i*DW +: DW]
r_valid / r_ready  out / in  1  result handshake
r_data  out  COL_NUM*DATA_WIDTH  element j = sum_i a_i*w[i][j]
arr_weights  out  ROW_NUM*COL_NUM*DATA_WIDTH  w[i][j] at [(i*COL_NUM+j)*DW +: DW]
arr_norths  out  COL_NUM*DATA_WIDTH  constant 0
arr_wests  out  ROW_NUM*DATA_WIDTH  skewed activations
arr_souths  in  COL_NUM*DATA_WIDTH  array south outputs

Behaviour:
- LAT = ROW_NUM+COL_NUM. A transfer is valid&&ready at a rising edge.
- States:
  - IDLE: start=1 latches num_vec, busy<=1, goes to LOAD_W.
  - LOAD_W: w_ready=1. Each w transfer writes weight row r (r = 0..ROW_NUM-1, ascending). After row ROW_NUM-1 goes to STREAM, or to DRAIN if num_vec==0.
  - STREAM: issues exactly num_vec vectors, then goes to DRAIN.
  - DRAIN: waits until inflight==0, then returns to IDLE with done=1 for one cycle and busy<=0.
- w_ready=0 and a_ready=0 outside LOAD_W and STREAM respectively.
- Weights are registered. They hold from the end of LOAD_W until the next job's LOAD_W.
- Issue rule: a_ready = (state==STREAM) && (issued<num_vec) && (fifo_count+inflight < OUT_DEPTH). Counts are the registered values; a same-cycle pop is not credited.
- Skew: a_i accepted at edge E0 appears on arr_wests[i] after edge E0+i and holds one cycle. Cycles with no issue drive 0 into the skew line.
- De-skew: column j is delayed COL_NUM-1-j registers, so all COL_NUM elements align.
- A 1-bit tag pipeline of length LAT follows each issue. The result is written into the FIFO at edge E0+LAT, so r_valid is high after that edge when the FIFO was empty. Untagged (bubble) slots are never written.
- inflight counts issued vectors not yet written; it updates on issue and on write, and both may happen in the same cycle.
- FIFO: in order. r_data/r_valid come from FIFO head. A pop occurs on r_valid&&r_ready. Simultaneous push and pop at full or empty is legal; count is unchanged at full, and at empty the result passes through one cycle later.
- Results may remain in the FIFO after done. A new start is accepted with the FIFO non-empty; its credits account for the resident entries.
- Reset (any state, mid-job included) clears the following on the edge:
  - state to IDLE; busy, done, w_ready, a_ready, r_valid to 0
  - all counters, FIFO pointers and count
  - skew, de-skew and tag registers
  - weights to 0, so arr_weights, arr_wests and r_data read 0
- arr_norths is 0 at all times.

Test Plan:
- 4x4, identity weights, a=[1,2,3,4], r_ready=1 -> r_data=[1,2,3,4]; r_valid high after edge E0+8; done pulses once; busy low afterwards.
- Weights all 17, a=[16,0,0,1] -> every column 289 mod 256 = 33; result [33,33,33,33] (checks wrap).
- num_vec=20, random a with a_valid=1, r_ready=1 -> a_ready never drops after LOAD_W; 20 results on consecutive cycles in issue order; each matches the golden matrix-vector product.
- r_ready=0, num_vec=30, a_valid=1 -> exactly 16 accepts, then a_ready=0 and r_valid=1. Raise r_ready -> all 30 results arrive in order, with none lost or duplicated.
- num_vec=0 -> 4 weight beats accepted, then done pulses, state returns to IDLE, and r_valid stays 0.
- reset=0 for one edge mid-STREAM with 5 vectors in flight -> next cycle: busy=0, r_valid=0, arr_weights=0, no stale result ever emerges. A fresh job then produces correct results.
